// File: rtl/reset_seq.sv
// Global reset sequencer: qualifies the clock-generator lock, then releases
// per-subsystem resets in index order and records why the last reset happened.
module reset_seq #(
    parameter int unsigned NUM_STAGES    = 4,
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned STAGE_GAP     = 16,
    parameter int unsigned SW_HOLD       = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clk_ok,
    input  logic                  sw_req,
    output logic [NUM_STAGES-1:0] stage_reset,
    output logic                  done,
    output logic [1:0]            cause,
    output logic [7:0]            loss_cnt
);

    localparam int unsigned IdxW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam longint unsigned CntMax = (64'd1 << CNT_W) - 64'd1;

    localparam logic [CNT_W-1:0] StableLast = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GapLast    = CNT_W'(STAGE_GAP - 1);
    localparam logic [CNT_W-1:0] SwLast     = CNT_W'(SW_HOLD - 1);
    localparam logic [IdxW-1:0]  IdxLast    = IdxW'(NUM_STAGES - 1);

    localparam logic [1:0] CausePor  = 2'b00;
    localparam logic [1:0] CauseLoss = 2'b01;
    localparam logic [1:0] CauseSw   = 2'b10;

    if (NUM_STAGES < 1 || NUM_STAGES > 8) begin : g_bad_num_stages
        $error("reset_seq: NUM_STAGES must be 1..8");
    end
    if (CNT_W < 1 || CNT_W > 31) begin : g_bad_cnt_w
        $error("reset_seq: CNT_W must be 1..31");
    end
    if (STABLE_CYCLES < 1 || longint'(STABLE_CYCLES) > CntMax) begin : g_bad_stable
        $error("reset_seq: STABLE_CYCLES out of range for CNT_W");
    end
    if (STAGE_GAP < 1 || longint'(STAGE_GAP) > CntMax) begin : g_bad_gap
        $error("reset_seq: STAGE_GAP out of range for CNT_W");
    end
    if (SW_HOLD < 1 || longint'(SW_HOLD) > CntMax) begin : g_bad_sw_hold
        $error("reset_seq: SW_HOLD out of range for CNT_W");
    end

    typedef enum logic [2:0] {
        StHold,
        StSettle,
        StRelease,
        StRun,
        StSwrst
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [IdxW-1:0]  idx_q;
    logic             ok_meta_q;
    logic             ok_s_q;

    // clk_ok comes straight from the clock generator, so it is resynchronised.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ok_meta_q <= 1'b0;
            ok_s_q    <= 1'b0;
        end else begin
            ok_meta_q <= clk_ok;
            ok_s_q    <= ok_meta_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StHold;
            cnt_q       <= '0;
            idx_q       <= '0;
            stage_reset <= '1;
            done        <= 1'b0;
            cause       <= CausePor;
            loss_cnt    <= 8'd0;
        end else if (!ok_s_q &&
                     (state_q == StRelease || state_q == StRun || state_q == StSwrst)) begin
            // Loss of a qualified lock wins over sw_req and counter expiry.
            state_q     <= StHold;
            cnt_q       <= '0;
            stage_reset <= '1;
            done        <= 1'b0;
            cause       <= CauseLoss;
            if (loss_cnt != 8'hFF) begin
                loss_cnt <= loss_cnt + 8'd1;
            end
        end else begin
            unique case (state_q)
                StHold: begin
                    stage_reset <= '1;
                    done        <= 1'b0;
                    cnt_q       <= '0;
                    if (ok_s_q) begin
                        state_q <= StSettle;
                    end
                end
                StSettle: begin
                    if (!ok_s_q) begin
                        state_q <= StHold;
                        cnt_q   <= '0;
                    end else if (cnt_q == StableLast) begin
                        state_q <= StRelease;
                        cnt_q   <= '0;
                        idx_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                StRelease: begin
                    if (cnt_q == GapLast) begin
                        stage_reset[idx_q] <= 1'b0;
                        cnt_q              <= '0;
                        idx_q              <= idx_q + IdxW'(1);
                        if (idx_q == IdxLast) begin
                            state_q <= StRun;
                            done    <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                StRun: begin
                    if (sw_req) begin
                        state_q     <= StSwrst;
                        cnt_q       <= '0;
                        stage_reset <= '1;
                        done        <= 1'b0;
                        cause       <= CauseSw;
                    end
                end
                StSwrst: begin
                    if (cnt_q == SwLast) begin
                        state_q <= StSettle;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q     <= StHold;
                    cnt_q       <= '0;
                    stage_reset <= '1;
                    done        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reset_seq.sv
// Directed bench for reset_seq with short timing parameters; each scenario
// task drives its own stimulus and checks against hand-derived edge numbers.
module tb_reset_seq;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       clk_ok = 1'b0;
    logic       sw_req = 1'b0;
    logic [3:0] stage_reset;
    logic       done;
    logic [1:0] cause;
    logic [7:0] loss_cnt;

    int n_checks = 0;
    int n_errors = 0;

    reset_seq #(
        .NUM_STAGES   (4),
        .CNT_W        (16),
        .STABLE_CYCLES(8),
        .STAGE_GAP    (4),
        .SW_HOLD      (6)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .clk_ok     (clk_ok),
        .sw_req     (sw_req),
        .stage_reset(stage_reset),
        .done       (done),
        .cause      (cause),
        .loss_cnt   (loss_cnt)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle away from it.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Expected stage vector k edges in, stage 0 falling at edge `first`, gap 4.
    function automatic logic [3:0] exp_stage(input int k, input int first);
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = (k >= first + 4 * i) ? 1'b0 : 1'b1;
        return v;
    endfunction

    // Reset with clk_ok already high; the next rising edge is edge 1.
    task automatic power_up();
        reset_n = 1'b0;
        clk_ok  = 1'b1;
        sw_req  = 1'b0;
        tick(2);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        clk_ok  = 1'b0;
        tick(2);
        n_checks++;
        if (stage_reset !== 4'b1111 || done !== 1'b0 || cause !== 2'b00 || loss_cnt !== 8'd0) begin
            n_errors++;
            $display("FAIL reset_state: got stage=%b done=%b cause=%b loss=%0d want 1111/0/00/0",
                     stage_reset, done, cause, loss_cnt);
        end
    endtask

    task automatic test_power_on();
        logic [3:0] exp;
        power_up();
        for (int k = 1; k <= 30; k++) begin
            tick(1);
            exp = exp_stage(k, 15);
            n_checks++;
            if (stage_reset !== exp || done !== (k >= 27)) begin
                n_errors++;
                $display("FAIL power_on edge %0d: got stage=%b done=%b want %b/%b",
                         k, stage_reset, done, exp, (k >= 27));
            end
        end
        n_checks++;
        if (cause !== 2'b00 || loss_cnt !== 8'd0) begin
            n_errors++;
            $display("FAIL power_on_status: got cause=%b loss=%0d want 00/0", cause, loss_cnt);
        end
    endtask

    task automatic test_glitch_settle();
        logic [3:0] exp;
        power_up();
        for (int k = 1; k <= 40; k++) begin
            if (k == 8) clk_ok = 1'b0;
            if (k == 11) clk_ok = 1'b1;
            tick(1);
            // Glitch lands in SETTLE; qualification restarts from the edge-11 sample.
            exp = exp_stage(k, 25);
            n_checks++;
            if (stage_reset !== exp || done !== (k >= 37)) begin
                n_errors++;
                $display("FAIL glitch_settle edge %0d: got stage=%b done=%b want %b/%b",
                         k, stage_reset, done, exp, (k >= 37));
            end
        end
        n_checks++;
        if (cause !== 2'b00 || loss_cnt !== 8'd0) begin
            n_errors++;
            $display("FAIL glitch_status: got cause=%b loss=%0d want 00/0", cause, loss_cnt);
        end
    endtask

    task automatic test_lock_loss_run();
        logic [3:0] exp;
        power_up();
        tick(30);
        clk_ok = 1'b0;
        tick(3);
        n_checks++;
        if (stage_reset !== 4'b1111 || done !== 1'b0 || cause !== 2'b01 || loss_cnt !== 8'd1) begin
            n_errors++;
            $display("FAIL loss_run: got stage=%b done=%b cause=%b loss=%0d want 1111/0/01/1",
                     stage_reset, done, cause, loss_cnt);
        end
        tick(2);
        clk_ok = 1'b1;
        for (int k = 1; k <= 28; k++) begin
            tick(1);
            exp = exp_stage(k, 15);
            n_checks++;
            if (stage_reset !== exp || done !== (k >= 27)) begin
                n_errors++;
                $display("FAIL loss_run_rerelease edge %0d: got stage=%b done=%b want %b/%b",
                         k, stage_reset, done, exp, (k >= 27));
            end
        end
    endtask

    task automatic test_loss_mid_release();
        logic [3:0] exp;
        power_up();
        tick(19);
        n_checks++;
        if (stage_reset !== 4'b1100) begin
            n_errors++;
            $display("FAIL mid_release_pre: got stage=%b want 1100", stage_reset);
        end
        clk_ok = 1'b0;
        tick(3);
        n_checks++;
        if (stage_reset !== 4'b1111 || done !== 1'b0 || cause !== 2'b01 || loss_cnt !== 8'd1) begin
            n_errors++;
            $display("FAIL mid_release_abort: got stage=%b done=%b cause=%b loss=%0d want 1111/0/01/1",
                     stage_reset, done, cause, loss_cnt);
        end
        tick(3);
        clk_ok = 1'b1;
        for (int k = 1; k <= 27; k++) begin
            tick(1);
            exp = exp_stage(k, 15);
            n_checks++;
            if (stage_reset !== exp) begin
                n_errors++;
                $display("FAIL mid_release_resettle edge %0d: got stage=%b want %b",
                         k, stage_reset, exp);
            end
        end
    endtask

    task automatic test_sw_reset();
        logic [3:0] exp;
        power_up();
        tick(30);
        sw_req = 1'b1;
        tick(1);
        sw_req = 1'b0;
        n_checks++;
        if (stage_reset !== 4'b1111 || done !== 1'b0 || cause !== 2'b10) begin
            n_errors++;
            $display("FAIL sw_entry: got stage=%b done=%b cause=%b want 1111/0/10",
                     stage_reset, done, cause);
        end
        // 6 SWRST + 8 SETTLE + 4 gap: stage 0 falls 18 edges after entry.
        for (int k = 1; k <= 30; k++) begin
            sw_req = (k == 9 || k == 10) ? 1'b1 : 1'b0;
            tick(1);
            exp = exp_stage(k, 18);
            n_checks++;
            if (stage_reset !== exp || done !== (k >= 30)) begin
                n_errors++;
                $display("FAIL sw_release edge %0d: got stage=%b done=%b want %b/%b",
                         k, stage_reset, done, exp, (k >= 30));
            end
        end
        sw_req = 1'b0;
        n_checks++;
        if (cause !== 2'b10 || loss_cnt !== 8'd0) begin
            n_errors++;
            $display("FAIL sw_status: got cause=%b loss=%0d want 10/0", cause, loss_cnt);
        end
    endtask

    task automatic test_async_reset_and_saturation();
        logic [7:0] exp_cnt;
        power_up();
        tick(30);
        sw_req = 1'b1;
        tick(1);
        sw_req = 1'b0;
        tick(3);
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (stage_reset !== 4'b1111 || done !== 1'b0 || cause !== 2'b00 || loss_cnt !== 8'd0) begin
            n_errors++;
            $display("FAIL async_reset: got stage=%b done=%b cause=%b loss=%0d want 1111/0/00/0",
                     stage_reset, done, cause, loss_cnt);
        end
        power_up();
        for (int i = 0; i < 256; i++) begin
            clk_ok = 1'b1;
            tick(11);
            clk_ok = 1'b0;
            tick(3);
            if (i == 0 || i == 253 || i == 254 || i == 255) begin
                exp_cnt = (i >= 254) ? 8'd255 : 8'(i + 1);
                n_checks++;
                if (loss_cnt !== exp_cnt || cause !== 2'b01 || stage_reset !== 4'b1111) begin
                    n_errors++;
                    $display("FAIL loss_sat event %0d: got loss=%0d cause=%b stage=%b want %0d/01/1111",
                             i + 1, loss_cnt, cause, stage_reset, exp_cnt);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_power_on();
        test_glitch_settle();
        test_lock_loss_run();
        test_loss_mid_release();
        test_sw_reset();
        test_async_reset_and_saturation();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
